csi_packet_parser: RTL and testbench
====================================

CSI_PACKET_PARSER -- requirements
Module: csi_packet_parser

Interface
REQ-001 Parameters (name, default, meaning):
- VC_SEL, 2'd0: virtual channel accepted.
- DT_RAW10, 6'h2B: data type forwarded as pixel payload.
REQ-002 Ports (name, direction, width, meaning):
- rxbyteclkhs, in, 1: byte clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high.
- data_in, in, 16: lane-merged bytes; [7:0] is the earlier byte, [15:8] the later byte.
- data_valid, in, 1: high for every cycle of an HS burst.
- data_out, out, 16: payload bytes, same byte order as data_in.
- frame_active, out, 1: high between accepted Frame Start and Frame End.
- frame_valid, out, 1: data_out carries RAW10 payload this cycle.
- line_count, out, 16: RAW10 lines completed in the current frame.
- frame_count, out, 16: Frame End packets accepted since reset.
- ecc_err, out, 1: one-cycle pulse on header ECC mismatch.
- pkt_err, out, 1: one-cycle pulse on burst abort or odd RAW10 word count.

Function
REQ-003 Header layout: cycle H0 gives DI=data_in[7:0] and WC[7:0]=data_in[15:8]. Cycle H1 gives WC[15:8]=data_in[7:0] and ECC=data_in[15:8]. DI[7:6]=VC, DI[5:0]=DT.
REQ-004 FSM states: IDLE, HDR, PAYLOAD, CRC, WAIT_EOT.
REQ-005 IDLE: on data_valid, capture H0 and go to HDR.
REQ-006 HDR: capture H1 and compute ECC over {WC,DI} (24 bits, MIPI CSI-2 Hamming table, ECC[7:6]=0).
- ECC mismatch: ecc_err pulse, go to WAIT_EOT.
- Match: decode in the same cycle per REQ-007 to REQ-009.
REQ-007 Short packet (DT<0x10) with VC=VC_SEL:
- DT 0x00 (Frame Start): frame_active<=1, line_count<=0.
- DT 0x01 (Frame End): frame_active<=0, frame_count<=frame_count+1 (wraps at 16'hFFFF).
- All other short DTs: no effect.
- Next state is WAIT_EOT.
REQ-008 Long packet: load byte counter rem<=WC.
- WC=0: go to CRC.
- Otherwise: go to PAYLOAD.
REQ-009 A long packet with VC=VC_SEL, DT=DT_RAW10 and WC[0]=1 raises pkt_err and is skipped: payload bytes are consumed with frame_valid held low.
REQ-010 PAYLOAD: each cycle rem<=rem-2. When rem<=2, go to CRC.
- Forwarding condition: matching VC, DT=DT_RAW10, even WC.
- When met: data_out<=data_in and frame_valid<=1, registered, 1-cycle latency.
- Otherwise: frame_valid<=0 and data_out<=0.
REQ-011 Odd rem=1 on a non-RAW10 packet: the final cycle consumes 1 payload byte plus 1 CRC byte, then goes to CRC; the CRC is discarded.
REQ-012 CRC: discard 16 bits; frame_valid<=0. On a forwarded RAW10 packet, line_count<=line_count+1. Go to WAIT_EOT.
REQ-013 WAIT_EOT: stay while data_valid=1; go to IDLE when data_valid=0.
REQ-014 data_valid=0 in HDR or PAYLOAD:
- Raise pkt_err and go to IDLE.
- frame_valid<=0.
- line_count is unchanged.
- frame_active is unchanged.
REQ-015 data_valid=0 in CRC: go to IDLE.
REQ-016 frame_valid is never high for two packets without at least one low cycle between them.
REQ-017 Outputs change only on a clock edge; no combinational path from input to output.

Reset
REQ-018 When reset=1 at a clock edge:
- State<=IDLE.
- data_out, frame_active, frame_valid, line_count, frame_count, ecc_err, pkt_err, rem <= 0.
REQ-019 Reset takes priority over all other events, including mid-packet. The first header is accepted on the first data_valid cycle after reset is released.

Structure
REQ-020 Shared package csi_pkg holds:
- DT constants: DT_FS=6'h00, DT_FE=6'h01, DT_RAW10=6'h2B.
- Header field widths.
- The ECC-generation function.
REQ-021 Sub-module csi_ecc_check: combinational 24-bit to 6-bit ECC generation and compare, instantiated once.

Verification
REQ-022 FS short packet (DI 0x00, WC 0x0001, valid ECC), burst ends -> frame_active rises 1 cycle after H1; line_count=0.
REQ-023 RAW10 long packet (DI 0x2B, WC 10, payload bytes 0x01..0x0A, CRC) -> frame_valid high for exactly 5 cycles, starting 1 cycle after the first payload cycle; data_out=0x0201, 0x0403, ... 0x0A09; then line_count=1.
REQ-024 Long packet DT 0x12 with WC 7 -> frame_valid stays 0; FSM returns to IDLE after data_valid falls; the next FS is accepted.
REQ-025 FS header with one ECC bit flipped -> ecc_err single pulse; frame_active stays 0.
REQ-026 data_valid drops after 2 of 5 payload cycles -> pkt_err pulse; frame_valid low the next cycle; line_count unchanged.
REQ-027 reset asserted mid-payload -> all outputs 0 at the next edge; a following FE packet increments frame_count to 1.

Source files
------------

// File: rtl/csi_pkg.sv
// Shared CSI-2 packet definitions: header field widths, data types,
// parser state encoding and the header ECC generator.
package csi_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DI_W   = 8;
  localparam int unsigned WC_W   = 16;
  localparam int unsigned ECC_W  = 8;
  localparam int unsigned VC_W   = 2;
  localparam int unsigned DT_W   = 6;
  localparam int unsigned HDR_W  = DI_W + WC_W;

  localparam logic [DT_W-1:0] DT_FS       = 6'h00;
  localparam logic [DT_W-1:0] DT_FE       = 6'h01;
  localparam logic [DT_W-1:0] DT_RAW10    = 6'h2B;
  localparam logic [DT_W-1:0] DT_LONG_MIN = 6'h10;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    CRC,
    WAIT_EOT
  } csi_state_t;

  // Hamming parity over the 24-bit packet header {WC, DI}; bit 0 is DI[0].
  function automatic logic [5:0] csi_ecc(input logic [HDR_W-1:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return p;
  endfunction

endpackage

// File: rtl/csi_packet_parser_if.sv
// Lane-merged HS byte stream entering the packet parser.
interface csi_packet_parser_if;
  import csi_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              data_valid;

  modport master (output data_in, data_valid);
  modport slave  (input  data_in, data_valid);
endinterface

// File: rtl/csi_ecc_check.sv
// Combinational header ECC generation and compare against the received ECC byte.
module csi_ecc_check
  import csi_pkg::*;
(
  input  logic [HDR_W-1:0] hdr,
  input  logic [ECC_W-1:0] ecc_rx,
  output logic             ecc_ok
);

  // Received ECC must match the generated parity with its two spare bits clear.
  always_comb begin
    ecc_ok = (ecc_rx == {2'b00, csi_ecc(hdr)});
  end

endmodule

// File: rtl/csi_packet_parser.sv
// CSI-2 packet parser: header decode with ECC check, frame/line tracking and
// forwarding of RAW10 payload on the selected virtual channel.
module csi_packet_parser #(
  parameter logic [1:0] VC_SEL   = 2'd0,
  parameter logic [5:0] DT_RAW10 = 6'h2B
) (
  input  logic                rxbyteclkhs,
  input  logic                reset,
  csi_packet_parser_if.slave  rx,
  output logic [15:0]         data_out,
  output logic                frame_active,
  output logic                frame_valid,
  output logic [15:0]         line_count,
  output logic [15:0]         frame_count,
  output logic                ecc_err,
  output logic                pkt_err
);
  import csi_pkg::*;

  csi_state_t        state_q, state_d;
  logic [DI_W-1:0]   di_q, di_d;
  logic [7:0]        wc_lo_q, wc_lo_d;
  logic [WC_W-1:0]   rem_q, rem_d;
  logic              fwd_q, fwd_d;

  logic [15:0]       data_out_d;
  logic              frame_active_d;
  logic              frame_valid_d;
  logic [15:0]       line_count_d;
  logic [15:0]       frame_count_d;
  logic              ecc_err_d;
  logic              pkt_err_d;

  logic [WC_W-1:0]   hdr_wc;
  logic [VC_W-1:0]   hdr_vc;
  logic [DT_W-1:0]   hdr_dt;
  logic              hdr_ecc_ok;
  logic              vc_match;
  logic              raw_match;

  // Header fields: H0 is held in di_q/wc_lo_q, H1 is on the bus during HDR.
  always_comb begin
    hdr_wc    = {rx.data_in[7:0], wc_lo_q};
    hdr_vc    = di_q[7:6];
    hdr_dt    = di_q[5:0];
    vc_match  = (hdr_vc == VC_SEL);
    raw_match = vc_match && (hdr_dt == DT_RAW10);
  end

  csi_ecc_check u_ecc_check (
    .hdr    ({hdr_wc, di_q}),
    .ecc_rx (rx.data_in[15:8]),
    .ecc_ok (hdr_ecc_ok)
  );

  // Next-state and next-output decode; pulses and forwarding default low each cycle.
  always_comb begin
    state_d        = state_q;
    di_d           = di_q;
    wc_lo_d        = wc_lo_q;
    rem_d          = rem_q;
    fwd_d          = fwd_q;
    data_out_d     = '0;
    frame_valid_d  = 1'b0;
    frame_active_d = frame_active;
    line_count_d   = line_count;
    frame_count_d  = frame_count;
    ecc_err_d      = 1'b0;
    pkt_err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx.data_valid) begin
          di_d    = rx.data_in[7:0];
          wc_lo_d = rx.data_in[15:8];
          state_d = HDR;
        end
      end

      HDR: begin
        if (!rx.data_valid) begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end else if (!hdr_ecc_ok) begin
          ecc_err_d = 1'b1;
          state_d   = WAIT_EOT;
        end else if (hdr_dt < DT_LONG_MIN) begin
          if (vc_match) begin
            if (hdr_dt == DT_FS) begin
              frame_active_d = 1'b1;
              line_count_d   = '0;
            end else if (hdr_dt == DT_FE) begin
              frame_active_d = 1'b0;
              frame_count_d  = frame_count + 16'd1;
            end
          end
          state_d = WAIT_EOT;
        end else begin
          rem_d = hdr_wc;
          fwd_d = raw_match && !hdr_wc[0];
          if (raw_match && hdr_wc[0]) begin
            pkt_err_d = 1'b1;
          end
          state_d = (hdr_wc == '0) ? CRC : PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (!rx.data_valid) begin
          pkt_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          frame_valid_d = fwd_q;
          data_out_d    = fwd_q ? rx.data_in : '0;
          // An odd tail (rem=1) shares its word with the first CRC byte; clamp to 0.
          if (rem_q <= 16'd2) begin
            rem_d   = '0;
            state_d = CRC;
          end else begin
            rem_d = rem_q - 16'd2;
          end
        end
      end

      CRC: begin
        if (!rx.data_valid) begin
          state_d = IDLE;
        end else begin
          if (fwd_q) begin
            line_count_d = line_count + 16'd1;
          end
          state_d = WAIT_EOT;
        end
      end

      WAIT_EOT: begin
        if (!rx.data_valid) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous reset clears everything.
  always_ff @(posedge rxbyteclkhs) begin
    if (reset) begin
      state_q      <= IDLE;
      di_q         <= '0;
      wc_lo_q      <= '0;
      rem_q        <= '0;
      fwd_q        <= 1'b0;
      data_out     <= '0;
      frame_active <= 1'b0;
      frame_valid  <= 1'b0;
      line_count   <= '0;
      frame_count  <= '0;
      ecc_err      <= 1'b0;
      pkt_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      di_q         <= di_d;
      wc_lo_q      <= wc_lo_d;
      rem_q        <= rem_d;
      fwd_q        <= fwd_d;
      data_out     <= data_out_d;
      frame_active <= frame_active_d;
      frame_valid  <= frame_valid_d;
      line_count   <= line_count_d;
      frame_count  <= frame_count_d;
      ecc_err      <= ecc_err_d;
      pkt_err      <= pkt_err_d;
    end
  end

endmodule

// File: tb/tb_csi_packet_parser.sv
// Self-checking bench for csi_packet_parser: packet table, hand-written timing
// and reset sequences, then randomized packets against a transaction-level model.
module tb_csi_packet_parser;

  logic        rxbyteclkhs = 1'b0;
  logic        reset;
  logic [15:0] data_out;
  logic        frame_active;
  logic        frame_valid;
  logic [15:0] line_count;
  logic [15:0] frame_count;
  logic        ecc_err;
  logic        pkt_err;

  csi_packet_parser_if rx_if ();

  csi_packet_parser #(.VC_SEL(2'd0), .DT_RAW10(6'h2B)) dut (
    .rxbyteclkhs  (rxbyteclkhs),
    .reset        (reset),
    .rx           (rx_if),
    .data_out     (data_out),
    .frame_active (frame_active),
    .frame_valid  (frame_valid),
    .line_count   (line_count),
    .frame_count  (frame_count),
    .ecc_err      (ecc_err),
    .pkt_err      (pkt_err)
  );

  always #5 rxbyteclkhs = ~rxbyteclkhs;

  int errors = 0;
  int checks = 0;

  // Monitor-owned observations (only the monitor writes these).
  logic [15:0] got_q[$];
  int ecc_total = 0;
  int pkt_total = 0;
  int bad_total = 0;

  // Snapshots taken at the start of each packet.
  int got_base, ecc_base, pkt_base, bad_base;
  logic [7:0] sent_pay[$];

  always @(negedge rxbyteclkhs) begin
    if (!reset) begin
      if (frame_valid) got_q.push_back(data_out);
      else if (data_out != 16'h0) bad_total++;
      if (ecc_err) ecc_total++;
      if (pkt_err) pkt_total++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference header ECC: each parity bit is the XOR of the header bits in its mask.
  function automatic logic [7:0] ref_ecc(input logic [23:0] d);
    logic [23:0] m [6];
    logic [7:0]  e;
    m[0] = 24'hF12CB7; m[1] = 24'hF2555B; m[2] = 24'h749A6D;
    m[3] = 24'hB8E38E; m[4] = 24'hDF03F0; m[5] = 24'hEFFC00;
    e = '0;
    for (int i = 0; i < 6; i++) e[i] = ^(d & m[i]);
    return e;
  endfunction

  // Builds the byte stream of one packet and drives it as a burst; abort_after>=0
  // truncates the burst after that many payload words.
  task automatic send_packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                             input bit flip, input int abort_after, input bit seq);
    logic [7:0] bs[$];
    logic [7:0] di, ecc, b;
    int nwords, idx;
    di  = {vc, dt};
    ecc = ref_ecc({wc, di});
    if (flip) begin
      idx = int'($urandom_range(0, 5));
      ecc[idx] = ~ecc[idx];
    end
    bs = {di, wc[7:0], wc[15:8], ecc};
    @(posedge rxbyteclkhs); #1;
    sent_pay.delete();
    got_base = got_q.size();
    ecc_base = ecc_total;
    pkt_base = pkt_total;
    bad_base = bad_total;
    if (dt >= 6'h10) begin
      for (int i = 0; i < int'(wc); i++) begin
        b = seq ? 8'(i + 1) : 8'($urandom);
        sent_pay.push_back(b);
        bs.push_back(b);
      end
      bs.push_back(8'hC3);
      bs.push_back(8'h5A);
      if (bs.size() % 2 != 0) bs.push_back(8'h00);
    end
    nwords = bs.size() / 2;
    if (abort_after >= 0) nwords = 2 + abort_after;
    for (int k = 0; k < nwords; k++) begin
      if (k > 0) begin @(posedge rxbyteclkhs); #1; end
      rx_if.data_in    = {bs[2*k+1], bs[2*k]};
      rx_if.data_valid = 1'b1;
    end
    @(posedge rxbyteclkhs); #1;
    rx_if.data_valid = 1'b0;
    rx_if.data_in    = 16'($urandom);
    repeat (3) @(posedge rxbyteclkhs);
    @(negedge rxbyteclkhs);
  endtask

  task automatic check_pkt(input string tag, input int words, input bit act, input int lines,
                           input int frames, input int ecc, input int pkt);
    int n;
    n = got_q.size() - got_base;
    check({tag, " words"}, n, words);
    for (int k = 0; k < n && 2*k+1 < sent_pay.size(); k++)
      check({tag, " data"}, int'(got_q[got_base+k]), int'({sent_pay[2*k+1], sent_pay[2*k]}));
    check({tag, " frame_active"}, int'(frame_active), int'(act));
    check({tag, " line_count"}, int'(line_count), lines);
    check({tag, " frame_count"}, int'(frame_count), frames);
    check({tag, " ecc_err"}, ecc_total - ecc_base, ecc);
    check({tag, " pkt_err"}, pkt_total - pkt_base, pkt);
    check({tag, " idle_data_zero"}, bad_total - bad_base, 0);
  endtask

  typedef struct {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    bit          flip;
    int          ab;
    int          words;
    bit          act;
    int          lines;
    int          frames;
    int          ecc;
    int          pkt;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          m_act;
    int          m_lines, m_frames;
    logic [15:0] wv[8];
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [5:0]  dts[7];
    bit          flip, raw, fwd;
    int          ab, e_words, e_ecc, e_pkt;

    //           vc     dt     wc       flip  ab  words act lines frames ecc pkt
    vecs[0]  = '{2'd0, 6'h00, 16'd1,  1'b1, -1, 0, 1'b0, 0, 0, 1, 0};
    vecs[1]  = '{2'd0, 6'h00, 16'd1,  1'b0, -1, 0, 1'b1, 0, 0, 0, 0};
    vecs[2]  = '{2'd0, 6'h2B, 16'd10, 1'b0, -1, 5, 1'b1, 1, 0, 0, 0};
    vecs[3]  = '{2'd0, 6'h12, 16'd7,  1'b0, -1, 0, 1'b1, 1, 0, 0, 0};
    vecs[4]  = '{2'd0, 6'h00, 16'd1,  1'b0, -1, 0, 1'b1, 0, 0, 0, 0};
    vecs[5]  = '{2'd0, 6'h2B, 16'd10, 1'b0,  2, 2, 1'b1, 0, 0, 0, 1};
    vecs[6]  = '{2'd0, 6'h2B, 16'd9,  1'b0, -1, 0, 1'b1, 0, 0, 0, 1};
    vecs[7]  = '{2'd1, 6'h2B, 16'd4,  1'b0, -1, 0, 1'b1, 0, 0, 0, 0};
    vecs[8]  = '{2'd0, 6'h2B, 16'd0,  1'b0, -1, 0, 1'b1, 1, 0, 0, 0};
    vecs[9]  = '{2'd0, 6'h2B, 16'd4,  1'b0, -1, 2, 1'b1, 2, 0, 0, 0};
    vecs[10] = '{2'd1, 6'h01, 16'd0,  1'b0, -1, 0, 1'b1, 2, 0, 0, 0};
    vecs[11] = '{2'd0, 6'h05, 16'd3,  1'b0, -1, 0, 1'b1, 2, 0, 0, 0};
    vecs[12] = '{2'd0, 6'h01, 16'd0,  1'b0, -1, 0, 1'b0, 2, 1, 0, 0};
    vecs[13] = '{2'd0, 6'h2A, 16'd3,  1'b0, -1, 0, 1'b0, 2, 1, 0, 0};

    reset = 1'b1;
    rx_if.data_valid = 1'b0;
    rx_if.data_in    = 16'h0;
    repeat (3) @(posedge rxbyteclkhs);
    #1;
    check("reset data_out", int'(data_out), 0);
    check("reset frame_active", int'(frame_active), 0);
    check("reset frame_valid", int'(frame_valid), 0);
    check("reset line_count", int'(line_count), 0);
    check("reset frame_count", int'(frame_count), 0);
    check("reset ecc_err", int'(ecc_err), 0);
    check("reset pkt_err", int'(pkt_err), 0);
    reset = 1'b0;

    for (int r = 0; r < NV; r++) begin
      send_packet(vecs[r].vc, vecs[r].dt, vecs[r].wc, vecs[r].flip, vecs[r].ab, 1'b1);
      check_pkt($sformatf("vec%0d", r), vecs[r].words, vecs[r].act, vecs[r].lines,
                vecs[r].frames, vecs[r].ecc, vecs[r].pkt);
    end
    m_act    = vecs[NV-1].act;
    m_lines  = vecs[NV-1].lines;
    m_frames = vecs[NV-1].frames;

    // Frame Start: frame_active rises in the cycle after H1.
    @(posedge rxbyteclkhs); #1;
    rx_if.data_in = 16'h0100; rx_if.data_valid = 1'b1;
    @(posedge rxbyteclkhs); #1;
    rx_if.data_in = {ref_ecc(24'h000100), 8'h00};
    @(negedge rxbyteclkhs);
    check("fs_timing during_h1", int'(frame_active), 0);
    @(posedge rxbyteclkhs); #1;
    rx_if.data_valid = 1'b0;
    @(negedge rxbyteclkhs);
    check("fs_timing after_h1", int'(frame_active), 1);
    check("fs_timing line_count", int'(line_count), 0);
    m_act = 1'b1; m_lines = 0;
    repeat (2) @(posedge rxbyteclkhs);

    // RAW10 line, cycle by cycle: frame_valid one cycle behind each payload word.
    wv[0] = {8'h0A, 8'h2B};
    wv[1] = {ref_ecc({16'd10, 8'h2B}), 8'h00};
    wv[2] = 16'h0201; wv[3] = 16'h0403; wv[4] = 16'h0605;
    wv[5] = 16'h0807; wv[6] = 16'h0A09; wv[7] = 16'h5AC3;
    for (int k = 0; k < 8; k++) begin
      @(posedge rxbyteclkhs); #1;
      rx_if.data_in = wv[k]; rx_if.data_valid = 1'b1;
      @(negedge rxbyteclkhs);
      check($sformatf("raw_timing fv c%0d", k), int'(frame_valid), (k >= 3) ? 1 : 0);
      if (k >= 3)
        check($sformatf("raw_timing data c%0d", k), int'(data_out), 32'h0201 + (k - 3) * 32'h0202);
    end
    @(posedge rxbyteclkhs); #1;
    rx_if.data_valid = 1'b0;
    @(negedge rxbyteclkhs);
    check("raw_timing fv_after", int'(frame_valid), 0);
    check("raw_timing line_count", int'(line_count), m_lines + 1);
    m_lines = m_lines + 1;
    repeat (2) @(posedge rxbyteclkhs);

    // Reset in the middle of a RAW10 payload, then a Frame End.
    for (int k = 0; k < 5; k++) begin
      @(posedge rxbyteclkhs); #1;
      rx_if.data_in = wv[k]; rx_if.data_valid = 1'b1;
    end
    reset = 1'b1;
    @(posedge rxbyteclkhs); #1;
    check("midreset data_out", int'(data_out), 0);
    check("midreset frame_active", int'(frame_active), 0);
    check("midreset frame_valid", int'(frame_valid), 0);
    check("midreset line_count", int'(line_count), 0);
    check("midreset frame_count", int'(frame_count), 0);
    check("midreset ecc_err", int'(ecc_err), 0);
    check("midreset pkt_err", int'(pkt_err), 0);
    reset = 1'b0;
    rx_if.data_valid = 1'b0;
    m_act = 1'b0; m_lines = 0; m_frames = 0;
    send_packet(2'd0, 6'h01, 16'd0, 1'b0, -1, 1'b1);
    m_frames = 1;
    check_pkt("fe_after_reset", 0, m_act, m_lines, m_frames, 0, 0);

    // Randomized packets against the transaction-level model.
    dts = '{6'h00, 6'h01, 6'h2B, 6'h2B, 6'h12, 6'h05, 6'h2A};
    for (int n = 0; n < 150; n++) begin
      vc   = (int'($urandom_range(0, 3)) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      dt   = dts[int'($urandom_range(0, 6))];
      wc   = (dt < 6'h10) ? 16'($urandom) : 16'($urandom_range(0, 14));
      flip = (int'($urandom_range(0, 9)) == 0);
      ab   = -1;
      if (dt >= 6'h10 && wc >= 16'd2 && int'($urandom_range(0, 5)) == 0)
        ab = int'($urandom_range(0, (int'(wc) + 1) / 2 - 1));

      e_words = 0; e_ecc = 0; e_pkt = 0;
      if (flip) begin
        e_ecc = 1;
      end else if (dt < 6'h10) begin
        if (vc == 2'd0 && dt == 6'h00) begin m_act = 1'b1; m_lines = 0; end
        if (vc == 2'd0 && dt == 6'h01) begin m_act = 1'b0; m_frames = (m_frames + 1) % 65536; end
      end else begin
        raw = (vc == 2'd0) && (dt == 6'h2B);
        fwd = raw && (wc % 2 == 0);
        if (raw && wc % 2 == 1) e_pkt++;
        if (ab >= 0) begin
          e_pkt++;
          if (fwd) e_words = ab;
        end else if (fwd) begin
          e_words = int'(wc) / 2;
          m_lines = (m_lines + 1) % 65536;
        end
      end
      send_packet(vc, dt, wc, flip, ab, 1'b0);
      check_pkt($sformatf("rnd%0d", n), e_words, m_act, m_lines, m_frames, e_ecc, e_pkt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
